johnson_decoder: RTL and testbench

Receive-side companion to the team's Johnson counter. Samples a WIDTH-bit Johnson code each valid cycle, decodes it to its binary position (0..2·WIDTH−1), flags illegal codes and out-of-sequence steps, and tracks lock to the incoming count stream with a small state machine. Used wherever a Johnson-coded count crosses a block boundary and must be checked and converted back to binary.

---
 rtl/johnson_pkg.sv | 17 +
 rtl/johnson_code_decode.sv | 33 +++
 rtl/johnson_decoder.sv | 157 +++++++++++++++
 tb/tb_johnson_decoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code receive path.
package johnson_pkg;

    typedef enum logic [1:0] {
        StUnlocked = 2'd0,
        StAcquire  = 2'd1,
        StLocked   = 2'd2
    } johnson_state_e;

    localparam int unsigned ErrCntW = 16;

    // Bits needed to hold a position in 0 .. 2*width-1.
    function automatic int unsigned johnson_cw(input int unsigned width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson-code checker: flags legal codes and converts them to a binary position.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = johnson_cw(WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic             legal,
    output logic [CW-1:0]    position
);

    localparam logic [CW:0] TwoW = (CW + 1)'(2 * WIDTH);

    logic [WIDTH-1:0] norm;
    logic [CW-1:0]    ones;
    logic [CW:0]      pos_wide;

    always_comb begin
        // Inverting a code with msb set maps 1..10..0 onto 0..01..1, so one check covers both.
        norm  = code[WIDTH-1] ? ~code : code;
        legal = ((norm & (norm + 1'b1)) == '0);

        ones = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + CW'(code[i]);
        end

        pos_wide = code[WIDTH-1] ? (TwoW - {1'b0, ones}) : {1'b0, ones};
        position = pos_wide[CW-1:0];
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes to binary, flags illegal and out-of-sequence samples, tracks lock.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOCK_CNT   = 4,
    parameter bit          ALLOW_HOLD = 1'b1,
    localparam int unsigned CW = johnson_cw(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   johnson_in,
    input  logic               err_clr,
    output logic [CW-1:0]      count,
    output logic               count_valid,
    output logic               illegal,
    output logic               seq_err,
    output logic               locked,
    output logic [ErrCntW-1:0] err_cnt
);

    localparam logic [CW-1:0] LastPos  = CW'(2 * WIDTH - 1);
    localparam logic [7:0]    LockCntL = 8'(LOCK_CNT);

    johnson_state_e     state_q, state_d;
    logic [CW-1:0]      ref_pos_q, ref_pos_d;
    logic               have_ref_q, have_ref_d;
    logic [7:0]         run_q, run_d;
    logic [CW-1:0]      count_q, count_d;
    logic               count_valid_q, illegal_q, seq_err_q;
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;

    logic          code_legal;
    logic [CW-1:0] code_pos;
    logic [CW-1:0] next_pos;
    logic          in_seq;
    logic          smp_illegal, smp_seq_err;
    logic [7:0]    run_inc;

    johnson_code_decode #(
        .WIDTH(WIDTH)
    ) u_decode (
        .code    (johnson_in),
        .legal   (code_legal),
        .position(code_pos)
    );

    always_comb begin
        next_pos    = (ref_pos_q == LastPos) ? '0 : ref_pos_q + 1'b1;
        in_seq      = !have_ref_q || (code_pos == next_pos) ||
                      (ALLOW_HOLD && (code_pos == ref_pos_q));
        smp_illegal = in_valid && !code_legal;
        smp_seq_err = in_valid && code_legal && !in_seq;
        run_inc     = run_q + 8'd1;
    end

    // Reference tracking and decoded count
    always_comb begin
        ref_pos_d  = ref_pos_q;
        have_ref_d = have_ref_q;
        count_d    = count_q;
        if (in_valid) begin
            if (code_legal) begin
                ref_pos_d  = code_pos;
                have_ref_d = 1'b1;
                count_d    = code_pos;
            end else begin
                have_ref_d = 1'b0;
            end
        end
    end

    // Lock FSM
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (in_valid) begin
            case (state_q)
                StUnlocked: begin
                    if (code_legal) begin
                        run_d   = 8'd1;
                        state_d = (LOCK_CNT == 1) ? StLocked : StAcquire;
                    end
                end
                StAcquire: begin
                    if (!code_legal) begin
                        run_d   = '0;
                        state_d = StUnlocked;
                    end else if (!in_seq) begin
                        run_d = 8'd1;
                    end else begin
                        run_d = run_inc;
                        if (run_inc >= LockCntL) begin
                            state_d = StLocked;
                        end
                    end
                end
                StLocked: begin
                    if (!code_legal) begin
                        run_d   = '0;
                        state_d = StUnlocked;
                    end else if (!in_seq) begin
                        run_d   = 8'd1;
                        state_d = StAcquire;
                    end
                end
                default: begin
                    run_d   = '0;
                    state_d = StUnlocked;
                end
            endcase
        end
    end

    // Saturating error counter; a clear overrides a coincident error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if ((smp_illegal || smp_seq_err) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StUnlocked;
            ref_pos_q     <= '0;
            have_ref_q    <= 1'b0;
            run_q         <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            ref_pos_q     <= ref_pos_d;
            have_ref_q    <= have_ref_d;
            run_q         <= run_d;
            count_q       <= count_d;
            count_valid_q <= in_valid && code_legal;
            illegal_q     <= smp_illegal;
            seq_err_q     <= smp_seq_err;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;
    assign locked      = (state_q == StLocked);
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomised scoreboard bench for johnson_decoder; runs a hold-tolerant and a hold-strict instance side by side.
module tb_johnson_decoder;

    typedef struct packed {
        logic [3:0]  cnt;
        logic        cv;
        logic        ill;
        logic        se;
        logic        lk;
        logic [15:0] ec;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  johnson_in;
    logic        err_clr;

    logic [3:0]  count_h, count_n;
    logic        cv_h, cv_n, ill_h, ill_n, se_h, se_n, lk_h, lk_n;
    logic [15:0] ec_h, ec_n;

    int checks = 0;
    int errors = 0;

    obs_t q_h[$];
    obs_t q_n[$];

    int m_ref[2], m_run[2], m_cnt[2], m_err[2];
    bit m_have[2];
    bit in_reset;

    johnson_decoder #(.WIDTH(8), .LOCK_CNT(4), .ALLOW_HOLD(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .johnson_in(johnson_in),
        .err_clr(err_clr), .count(count_h), .count_valid(cv_h), .illegal(ill_h),
        .seq_err(se_h), .locked(lk_h), .err_cnt(ec_h)
    );

    johnson_decoder #(.WIDTH(8), .LOCK_CNT(4), .ALLOW_HOLD(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .johnson_in(johnson_in),
        .err_clr(err_clr), .count(count_n), .count_valid(cv_n), .illegal(ill_n),
        .seq_err(se_n), .locked(lk_n), .err_cnt(ec_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Johnson code for position p: p ones from the LSB up to 8, then zeros filling in from the LSB.
    function automatic logic [7:0] gen_code(input int p);
        logic [7:0] m;
        if (p <= 8) m = 8'((1 << p) - 1);
        else        m = ~8'((1 << (p - 8)) - 1);
        return m;
    endfunction

    function automatic int lookup(input logic [7:0] c);
        for (int p = 0; p < 16; p++) begin
            if (gen_code(p) == c) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ref[k] = 0; m_run[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_have[k] = 0;
        end
    endtask

    // locked is modelled as "run of consecutive acceptable legal samples >= 4".
    task automatic model_step(input int k, input bit v, input logic [7:0] code, input bit clr,
                              output obs_t e);
        int p;
        bit ill, se, cv, inseq;
        ill = 0; se = 0; cv = 0;
        if (v) begin
            p = lookup(code);
            if (p < 0) begin
                ill = 1; m_have[k] = 0; m_run[k] = 0;
            end else begin
                inseq = !m_have[k] || (p == (m_ref[k] + 1) % 16) || (k == 0 && p == m_ref[k]);
                se = !inseq;
                cv = 1;
                m_cnt[k] = p; m_ref[k] = p; m_have[k] = 1;
                m_run[k] = se ? 1 : (m_run[k] < 1000 ? m_run[k] + 1 : m_run[k]);
            end
        end
        if (clr) m_err[k] = 0;
        else if ((ill || se) && m_err[k] < 65535) m_err[k]++;
        e.cnt = 4'(m_cnt[k]); e.cv = cv; e.ill = ill; e.se = se;
        e.lk = (m_run[k] >= 4); e.ec = 16'(m_err[k]);
    endtask

    task automatic push_now(input bit v, input logic [7:0] code, input bit clr);
        obs_t e0, e1;
        in_valid = v; johnson_in = code; err_clr = clr;
        if (in_reset) begin
            e0 = '0; e1 = '0;
        end else begin
            model_step(0, v, code, clr, e0);
            model_step(1, v, code, clr, e1);
        end
        q_h.push_back(e0);
        q_n.push_back(e1);
    endtask

    task automatic cyc(input bit v, input logic [7:0] code, input bit clr);
        @(negedge clk);
        push_now(v, code, clr);
    endtask

    task automatic compare(input string nm, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got cnt=%0d cv=%0b ill=%0b se=%0b lk=%0b ec=%0d, exp cnt=%0d cv=%0b ill=%0b se=%0b lk=%0b ec=%0d",
                     nm, $time, got.cnt, got.cv, got.ill, got.se, got.lk, got.ec,
                     exp.cnt, exp.cv, exp.ill, exp.se, exp.lk, exp.ec);
        end
    endtask

    // Monitor: every pushed expectation is matched against the outputs after the next edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_h.size() > 0) begin
                e = q_h.pop_front();
                compare("hold_dut", {count_h, cv_h, ill_h, se_h, lk_h, ec_h}, e);
            end
            if (q_n.size() > 0) begin
                e = q_n.pop_front();
                compare("strict_dut", {count_n, cv_n, ill_n, se_n, lk_n, ec_n}, e);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t got no finish, required finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int src, r;
        bit v, clr;
        logic [7:0] code;

        rst_n = 1'b0; in_valid = 1'b0; johnson_in = '0; err_clr = 1'b0;
        in_reset = 1; model_reset();
        repeat (2) cyc(0, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b1; in_reset = 0;
        push_now(0, 8'h00, 0);

        // Straight count with wrap 15 -> 0
        for (int i = 0; i < 18; i++) cyc(1, gen_code(i % 16), 0);

        // Illegal code then relock from position 2
        cyc(1, 8'b0010_1000, 0);
        for (int p = 2; p <= 5; p++) cyc(1, gen_code(p), 0);

        // Jump 5 -> 9 then continue
        for (int p = 9; p <= 12; p++) cyc(1, gen_code(p), 0);
        cyc(0, 8'h00, 0);

        // Walk to 6 and repeat it
        for (int i = 13; i <= 22; i++) cyc(1, gen_code(i % 16), 0);
        cyc(1, gen_code(6), 0);
        cyc(1, gen_code(6), 0);
        cyc(1, gen_code(7), 0);

        // Randomised mix: mostly successors, some holds, jumps, raw bytes and idle cycles
        src = 7;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                src = (src + 1) % 16; code = gen_code(src);
            end else if (r < 80) begin
                code = gen_code(src);
            end else if (r < 90) begin
                src = $urandom_range(0, 15); code = gen_code(src);
            end else begin
                code = 8'($urandom);
            end
            v = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 31) == 0);
            cyc(v, code, clr);
        end

        // Reset asserted mid-acquire with in_valid high
        cyc(1, 8'b0010_1000, 0);
        cyc(1, gen_code(3), 0);
        cyc(1, gen_code(4), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compare("async_reset_hold", {count_h, cv_h, ill_h, se_h, lk_h, ec_h}, '0);
        compare("async_reset_strict", {count_n, cv_n, ill_n, se_n, lk_n, ec_n}, '0);
        in_reset = 1; model_reset();
        repeat (2) cyc(1, 8'($urandom), 0);
        @(negedge clk);
        rst_n = 1'b1; in_reset = 0;
        push_now(1, gen_code(12), 0);
        for (int p = 13; p <= 16; p++) cyc(1, gen_code(p % 16), 0);

        // Drive the error counter into saturation, then clear against a coincident error
        for (int i = 0; i < 65540; i++) cyc(1, 8'b0010_1000, 0);
        cyc(1, 8'b0010_1000, 1);
        cyc(1, gen_code(3), 0);
        cyc(0, 8'h00, 0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q_h.size() != 0 || q_n.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending, required 0", q_h.size(), q_n.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
